// File: rtl/traffic_light_ctrl_param.sv
// Two-road (highway/farm) traffic light controller with parametrised timing.
// All durations are counted in 1 s ticks produced by an internal divider.
// Adds minimum highway green, all-red clearance, a latched farm request,
// early farm-green termination and a maintenance flash mode.
module traffic_light_ctrl_param #(
  parameter int TICK_DIV       = 4,
  parameter int DIV_W          = 28,
  parameter int T_W            = 8,
  parameter int MIN_GREEN_HW   = 5,
  parameter int MAX_GREEN_FARM = 10,
  parameter int MIN_GREEN_FARM = 3,
  parameter int T_YELLOW       = 3,
  parameter int T_ALLRED       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       C,
  input  logic       flash_en,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic [2:0] state_o,
  output logic       tick_o
);

  typedef enum logic [2:0] {
    HGRE_FRED = 3'd0,
    HYEL_FRED = 3'd1,
    ALLRED_A  = 3'd2,
    HRED_FGRE = 3'd3,
    HRED_FYEL = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6,
    ST_UNUSED = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [T_W-1:0]   T_ONE    = T_W'(1);
  localparam logic [T_W-1:0]   T_MAX    = {T_W{1'b1}};

  // "D elapsed" compares the timer against D-1 on a tick
  localparam logic [T_W-1:0] HW_MIN_LAST   = T_W'(MIN_GREEN_HW - 1);
  localparam logic [T_W-1:0] FARM_MAX_LAST = T_W'(MAX_GREEN_FARM - 1);
  localparam logic [T_W-1:0] FARM_MIN_LAST = T_W'(MIN_GREEN_FARM - 1);
  localparam logic [T_W-1:0] YEL_LAST      = T_W'(T_YELLOW - 1);
  localparam logic [T_W-1:0] ALLRED_LAST   = T_W'(T_ALLRED - 1);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div;
  logic [T_W-1:0]   timer;
  logic             req;
  logic             phase;
  logic             tick;

  assign tick    = (div == DIV_LAST);
  assign tick_o  = tick;
  assign state_o = state;

  // Free-running tick divider, independent of the state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                     div <= div + DIV_ONE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HGRE_FRED;
    else        state <= state_next;
  end

  // State timer: restarts on every state change, saturates otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        timer <= '0;
    else if (state_next != state)      timer <= '0;
    else if (tick && (timer != T_MAX)) timer <= timer + T_ONE;
  end

  // Farm request latch: consumed when farm green begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              req <= 1'b0;
    else if ((state_next == HRED_FGRE) && (state != HRED_FGRE)) req <= 1'b0;
    else if (C && (state != HRED_FGRE))                      req <= 1'b1;
  end

  // Flash phase: held at 0 outside FLASH so every entry starts dark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              phase <= 1'b0;
    else if (state != FLASH) phase <= 1'b0;
    else if (tick)           phase <= ~phase;
  end

  // Next-state logic; a flash request overrides any timed transition
  always_comb begin
    state_next = state;
    if ((state != FLASH) && flash_en) begin
      state_next = FLASH;
    end else begin
      case (state)
        HGRE_FRED: if (tick && req && (timer >= HW_MIN_LAST))   state_next = HYEL_FRED;
        HYEL_FRED: if (tick && (timer == YEL_LAST))             state_next = ALLRED_A;
        ALLRED_A:  if (tick && (timer == ALLRED_LAST))          state_next = HRED_FGRE;
        HRED_FGRE: if (tick && ((timer == FARM_MAX_LAST) ||
                                (!C && (timer >= FARM_MIN_LAST)))) state_next = HRED_FYEL;
        HRED_FYEL: if (tick && (timer == YEL_LAST))             state_next = ALLRED_B;
        ALLRED_B:  if (tick && (timer == ALLRED_LAST))          state_next = HGRE_FRED;
        FLASH:     if (!flash_en)                               state_next = ALLRED_B;
        default:                                                state_next = HGRE_FRED;
      endcase
    end
  end

  // Lamp decode from the registered state only (Moore outputs)
  always_comb begin
    light_highway = LAMP_RED;
    light_farm    = LAMP_RED;
    case (state)
      HGRE_FRED: light_highway = LAMP_GREEN;
      HYEL_FRED: light_highway = LAMP_YELLOW;
      HRED_FGRE: light_farm    = LAMP_GREEN;
      HRED_FYEL: light_farm    = LAMP_YELLOW;
      FLASH: begin
        light_highway = {1'b0, phase, 1'b0};
        light_farm    = {1'b0, phase, 1'b0};
      end
      default: begin
        light_highway = LAMP_RED;
        light_farm    = LAMP_RED;
      end
    endcase
  end

endmodule
